// File: rtl/rob_wide_pkg.sv
// rtl/rob_wide_pkg.sv - shared parameters and entry-kind encodings for the wide reorder buffer
package rob_wide_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int XLEN_DEF      = 32;

    typedef logic [1:0] kind_t;

    localparam kind_t KIND_REG    = 2'd0;
    localparam kind_t KIND_STORE  = 2'd1;
    localparam kind_t KIND_BRANCH = 2'd2;

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - two-slot commit eligibility and branch mispredict detection
module rob_commit_sel
    import rob_wide_pkg::*;
#(
    parameter int POS_W = 4
) (
    input  logic [POS_W:0] count,
    input  logic           ready_head,
    input  logic           ready_next,
    input  kind_t          kind_head,
    input  kind_t          kind_next,
    input  logic           pred_jump_head,
    input  logic           res_jump_head,
    output logic           commit0,
    output logic           commit1,
    output logic           mispredict
);

    logic head_plain;
    logic next_plain;

    // Stores and branches retire alone so their side-band pulses stay single-slot.
    assign head_plain = (kind_head != KIND_STORE) && (kind_head != KIND_BRANCH);
    assign next_plain = (kind_next != KIND_STORE) && (kind_next != KIND_BRANCH);

    assign commit0    = (count != '0) && ready_head;
    assign commit1    = commit0 && (count > (POS_W+1)'(1)) && ready_next && head_plain && next_plain;
    assign mispredict = commit0 && (kind_head == KIND_BRANCH) && (pred_jump_head != res_jump_head);

endmodule

// File: rtl/rob_wide.sv
// rtl/rob_wide.sv - reorder buffer with multi-port writeback, operand forwarding and dual commit
module rob_wide
    import rob_wide_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int WB_PORTS  = 2,
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_W     = 5,
    localparam int POS_W    = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [1:0]                issue_kind,
    input  logic [XLEN-1:0]           issue_pc,
    input  logic                      issue_pred_jump,
    input  logic                      issue_ready,
    input  logic [XLEN-1:0]           issue_val,
    output logic [POS_W-1:0]          issue_pos,
    output logic                      rob_full,
    input  logic [WB_PORTS-1:0]       wb_en,
    input  logic [WB_PORTS*POS_W-1:0] wb_pos,
    input  logic [WB_PORTS*XLEN-1:0]  wb_val,
    input  logic [WB_PORTS-1:0]       wb_jump,
    input  logic [WB_PORTS*XLEN-1:0]  wb_target,
    input  logic [POS_W-1:0]          rs1_pos,
    input  logic [POS_W-1:0]          rs2_pos,
    output logic                      rs1_ready,
    output logic                      rs2_ready,
    output logic [XLEN-1:0]           rs1_val,
    output logic [XLEN-1:0]           rs2_val,
    output logic [1:0]                cmt_en,
    output logic [2*REG_W-1:0]        cmt_rd,
    output logic [2*XLEN-1:0]         cmt_val,
    output logic [2*POS_W-1:0]        cmt_pos,
    output logic                      lsb_store,
    output logic [POS_W-1:0]          lsb_store_pos,
    output logic                      br_cmt,
    output logic                      br_cmt_jump,
    output logic [XLEN-1:0]           br_cmt_pc,
    output logic                      rollback,
    output logic                      set_pc_en,
    output logic [XLEN-1:0]           set_pc
);

    logic [POS_W-1:0] head, tail, head_nxt;
    logic [POS_W:0]   count, count_next;
    logic [ROB_DEPTH-1:0] valid_q, ready_q;

    kind_t            kind_q       [ROB_DEPTH];
    logic [REG_W-1:0] rd_q         [ROB_DEPTH];
    logic [XLEN-1:0]  pc_q         [ROB_DEPTH];
    logic [XLEN-1:0]  val_q        [ROB_DEPTH];
    logic [XLEN-1:0]  res_target_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] pred_jump_q, res_jump_q;

    logic [POS_W-1:0] wb_pos_a    [WB_PORTS];
    logic [XLEN-1:0]  wb_val_a    [WB_PORTS];
    logic [XLEN-1:0]  wb_target_a [WB_PORTS];

    logic issue_acc, commit0, commit1, mispredict;

    for (genvar k = 0; k < WB_PORTS; k++) begin : g_wb_unpack
        assign wb_pos_a[k]    = wb_pos[k*POS_W +: POS_W];
        assign wb_val_a[k]    = wb_val[k*XLEN +: XLEN];
        assign wb_target_a[k] = wb_target[k*XLEN +: XLEN];
    end

    assign head_nxt   = head + 1'b1;
    assign issue_acc  = issue && rdy && !rollback;
    assign issue_pos  = tail;
    assign rob_full   = count >= (POS_W+1)'(ROB_DEPTH-1);
    assign count_next = count + (POS_W+1)'(issue_acc) - (POS_W+1)'(commit0) - (POS_W+1)'(commit1);

    rob_commit_sel #(.POS_W(POS_W)) u_commit_sel (
        .count          (count),
        .ready_head     (ready_q[head]),
        .ready_next     (ready_q[head_nxt]),
        .kind_head      (kind_q[head]),
        .kind_next      (kind_q[head_nxt]),
        .pred_jump_head (pred_jump_q[head]),
        .res_jump_head  (res_jump_q[head]),
        .commit0        (commit0),
        .commit1        (commit1),
        .mispredict     (mispredict)
    );

    // Descending port loop so the lowest-numbered matching port ends up winning.
    always_comb begin
        rs1_ready = ready_q[rs1_pos];
        rs1_val   = val_q[rs1_pos];
        rs2_ready = ready_q[rs2_pos];
        rs2_val   = val_q[rs2_pos];
        for (int k = WB_PORTS-1; k >= 0; k--) begin
            if (wb_en[k] && wb_pos_a[k] == rs1_pos) begin
                rs1_ready = 1'b1;
                rs1_val   = wb_val_a[k];
            end
            if (wb_en[k] && wb_pos_a[k] == rs2_pos) begin
                rs2_ready = 1'b1;
                rs2_val   = wb_val_a[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            valid_q       <= '0;
            ready_q       <= '0;
            cmt_en        <= '0;
            cmt_rd        <= '0;
            cmt_val       <= '0;
            cmt_pos       <= '0;
            lsb_store     <= 1'b0;
            lsb_store_pos <= '0;
            br_cmt        <= 1'b0;
            br_cmt_jump   <= 1'b0;
            br_cmt_pc     <= '0;
            rollback      <= 1'b0;
            set_pc_en     <= 1'b0;
            set_pc        <= '0;
        end else if (rdy) begin
            cmt_en        <= {commit1 && kind_q[head_nxt] == KIND_REG, commit0 && kind_q[head] == KIND_REG};
            cmt_rd        <= {rd_q[head_nxt], rd_q[head]};
            cmt_val       <= {val_q[head_nxt], val_q[head]};
            cmt_pos       <= {head_nxt, head};
            lsb_store     <= commit0 && kind_q[head] == KIND_STORE;
            lsb_store_pos <= head;
            br_cmt        <= commit0 && kind_q[head] == KIND_BRANCH;
            br_cmt_jump   <= res_jump_q[head];
            br_cmt_pc     <= pc_q[head];
            rollback      <= mispredict;
            set_pc_en     <= mispredict;
            if (mispredict)
                set_pc <= res_target_q[head];

            // The flush lands on the same edge that raises rollback, so the pulse cycle sees an empty buffer.
            if (mispredict) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                valid_q <= '0;
                ready_q <= '0;
            end else if (!rollback) begin
                for (int k = WB_PORTS-1; k >= 0; k--)
                    if (wb_en[k] && valid_q[wb_pos_a[k]])
                        ready_q[wb_pos_a[k]] <= 1'b1;
                if (issue_acc) begin
                    valid_q[tail] <= 1'b1;
                    ready_q[tail] <= issue_ready;
                    tail          <= tail + 1'b1;
                end
                if (commit0) begin
                    valid_q[head] <= 1'b0;
                    ready_q[head] <= 1'b0;
                end
                if (commit1) begin
                    valid_q[head_nxt] <= 1'b0;
                    ready_q[head_nxt] <= 1'b0;
                end
                head  <= head + POS_W'(commit0) + POS_W'(commit1);
                count <= count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int k = WB_PORTS-1; k >= 0; k--) begin
                if (wb_en[k] && valid_q[wb_pos_a[k]]) begin
                    val_q[wb_pos_a[k]]        <= wb_val_a[k];
                    res_jump_q[wb_pos_a[k]]   <= wb_jump[k];
                    res_target_q[wb_pos_a[k]] <= wb_target_a[k];
                end
            end
            if (issue_acc) begin
                kind_q[tail]       <= issue_kind;
                rd_q[tail]         <= issue_rd;
                pc_q[tail]         <= issue_pc;
                pred_jump_q[tail]  <= issue_pred_jump;
                val_q[tail]        <= issue_val;
                res_jump_q[tail]   <= 1'b0;
                res_target_q[tail] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rob_wide.sv
// tb/tb_rob_wide.sv - directed self-checking bench for rob_wide
module tb_rob_wide;
    import rob_wide_pkg::*;

    localparam int D  = 16;
    localparam int P  = 2;
    localparam int X  = 32;
    localparam int R  = 5;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          issue;
    logic [R-1:0]  issue_rd;
    logic [1:0]    issue_kind;
    logic [X-1:0]  issue_pc;
    logic          issue_pred_jump, issue_ready;
    logic [X-1:0]  issue_val;
    logic [PW-1:0] issue_pos;
    logic          rob_full;
    logic [P-1:0]    wb_en;
    logic [P*PW-1:0] wb_pos;
    logic [P*X-1:0]  wb_val;
    logic [P-1:0]    wb_jump;
    logic [P*X-1:0]  wb_target;
    logic [PW-1:0] rs1_pos, rs2_pos;
    logic          rs1_ready, rs2_ready;
    logic [X-1:0]  rs1_val, rs2_val;
    logic [1:0]    cmt_en;
    logic [2*R-1:0]  cmt_rd;
    logic [2*X-1:0]  cmt_val;
    logic [2*PW-1:0] cmt_pos;
    logic          lsb_store;
    logic [PW-1:0] lsb_store_pos;
    logic          br_cmt, br_cmt_jump;
    logic [X-1:0]  br_cmt_pc;
    logic          rollback, set_pc_en;
    logic [X-1:0]  set_pc;

    int n_tests = 0;
    int n_fail  = 0;

    rob_wide #(.ROB_DEPTH(D), .WB_PORTS(P), .XLEN(X), .REG_W(R)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue(issue), .issue_rd(issue_rd), .issue_kind(issue_kind), .issue_pc(issue_pc),
        .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready), .issue_val(issue_val),
        .issue_pos(issue_pos), .rob_full(rob_full),
        .wb_en(wb_en), .wb_pos(wb_pos), .wb_val(wb_val), .wb_jump(wb_jump), .wb_target(wb_target),
        .rs1_pos(rs1_pos), .rs2_pos(rs2_pos), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_pos(cmt_pos),
        .lsb_store(lsb_store), .lsb_store_pos(lsb_store_pos),
        .br_cmt(br_cmt), .br_cmt_jump(br_cmt_jump), .br_cmt_pc(br_cmt_pc),
        .rollback(rollback), .set_pc_en(set_pc_en), .set_pc(set_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_one(input logic [R-1:0] rd_i, input logic [1:0] kind, input logic [X-1:0] pc,
                             input logic pred, input logic rdy_i, input logic [X-1:0] v);
        issue = 1'b1; issue_rd = rd_i; issue_kind = kind; issue_pc = pc;
        issue_pred_jump = pred; issue_ready = rdy_i; issue_val = v;
        step();
        issue = 1'b0;
    endtask

    task automatic set_wb(input int k, input logic [PW-1:0] pos, input logic [X-1:0] v,
                          input logic j, input logic [X-1:0] t);
        wb_en[k] = 1'b1;
        wb_pos[k*PW +: PW]  = pos;
        wb_val[k*X +: X]    = v;
        wb_jump[k]          = j;
        wb_target[k*X +: X] = t;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; issue = 1'b0; issue_rd = '0; issue_kind = '0; issue_pc = '0;
        issue_pred_jump = 1'b0; issue_ready = 1'b0; issue_val = '0;
        wb_en = '0; wb_pos = '0; wb_val = '0; wb_jump = '0; wb_target = '0;
        rs1_pos = '0; rs2_pos = '0;
        step(); step();
        check("rst_cmt_en", cmt_en, 0);
        check("rst_rollback", rollback, 0);
        check("rst_issue_pos", issue_pos, 0);
        check("rst_full", rob_full, 0);
        rst = 1'b0;

        // three reg-writes, dual then single commit
        issue_one(5'd1, KIND_REG, 0, 0, 0, 0);
        issue_one(5'd2, KIND_REG, 0, 0, 0, 0);
        issue_one(5'd3, KIND_REG, 0, 0, 0, 0);
        check("three_count", dut.count, 3);
        check("three_issue_pos", issue_pos, 3);
        set_wb(0, 4'd0, 32'h10, 0, 0);
        set_wb(1, 4'd1, 32'h11, 0, 0);
        step();
        wb_en = '0;
        set_wb(0, 4'd2, 32'h12, 0, 0);
        step();
        wb_en = '0;
        check("dual_cmt_en", cmt_en, 2'b11);
        check("dual_cmt_val", cmt_val, 64'h00000011_00000010);
        check("dual_cmt_rd", cmt_rd, 10'b00010_00001);
        check("dual_cmt_pos", cmt_pos, 8'h10);
        step();
        check("single_cmt_en", cmt_en, 2'b01);
        check("single_cmt_val", cmt_val[31:0], 32'h12);
        check("single_cmt_pos", cmt_pos[3:0], 2);
        check("three_count_end", dut.count, 0);
        step();
        check("cmt_en_drop", cmt_en, 0);

        // writeback collision at pos 4 and forwarding
        issue_one(5'd4, KIND_REG, 0, 0, 0, 0);
        issue_one(5'd5, KIND_REG, 0, 0, 0, 0);
        set_wb(0, 4'd4, 32'hA, 0, 0);
        set_wb(1, 4'd4, 32'hB, 0, 0);
        rs1_pos = 4'd4; rs2_pos = 4'd3;
        #1;
        check("fwd_rs1_ready", rs1_ready, 1);
        check("fwd_rs1_val", rs1_val, 32'hA);
        check("fwd_rs2_ready", rs2_ready, 0);
        step();
        wb_en = '0;
        #1;
        check("stored_rs1_ready", rs1_ready, 1);
        check("stored_rs1_val", rs1_val, 32'hA);
        set_wb(0, 4'd3, 32'h33, 0, 0);
        step();
        wb_en = '0;
        step();
        check("coll_cmt_en", cmt_en, 2'b11);
        check("coll_cmt_val", cmt_val, 64'h0000000A_00000033);
        step();

        // store behind a reg-write
        issue_one(5'd7, KIND_REG, 0, 0, 0, 0);
        issue_one(5'd0, KIND_STORE, 0, 0, 1, 0);
        set_wb(0, 4'd5, 32'h55, 0, 0);
        step();
        wb_en = '0;
        step();
        check("st_reg_cmt_en", cmt_en, 2'b01);
        check("st_reg_cmt_rd", cmt_rd[4:0], 7);
        check("st_early_lsb", lsb_store, 0);
        step();
        check("st_lsb_store", lsb_store, 1);
        check("st_lsb_pos", lsb_store_pos, 6);
        check("st_cmt_en_zero", cmt_en, 0);
        step();
        check("st_lsb_drop", lsb_store, 0);

        // mispredicted branch at pos 7
        issue_one(5'd0, KIND_BRANCH, 32'h40, 0, 0, 0);
        set_wb(0, 4'd7, 0, 1, 32'h100);
        step();
        wb_en = '0;
        step();
        check("br_rollback", rollback, 1);
        check("br_set_pc_en", set_pc_en, 1);
        check("br_set_pc", set_pc, 32'h100);
        check("br_cmt", br_cmt, 1);
        check("br_cmt_jump", br_cmt_jump, 1);
        check("br_cmt_pc", br_cmt_pc, 32'h40);
        check("br_count_flush", dut.count, 0);
        issue_one(5'd9, KIND_REG, 0, 0, 1, 0);
        check("br_rollback_drop", rollback, 0);
        check("br_set_pc_en_drop", set_pc_en, 0);
        check("br_issue_ignored", issue_pos, 0);
        check("br_count_after", dut.count, 0);

        // fill to 15, drain one, wrap tail
        for (int i = 0; i < 14; i++)
            issue_one(R'(i), KIND_REG, 0, 0, 0, 0);
        check("fill14_full", rob_full, 0);
        issue_one(5'd14, KIND_REG, 0, 0, 0, 0);
        check("fill15_full", rob_full, 1);
        check("fill15_pos", issue_pos, 15);
        set_wb(0, 4'd0, 32'h1, 0, 0);
        step();
        wb_en = '0;
        step();
        check("drain_full", rob_full, 0);
        check("drain_count", dut.count, 14);
        issue_one(5'd15, KIND_REG, 0, 0, 0, 0);
        check("wrap_pos", issue_pos, 0);
        check("wrap_full", rob_full, 1);
        set_wb(0, 4'd1, 32'h2, 0, 0);
        step();
        wb_en = '0;
        issue_one(5'd16, KIND_REG, 0, 0, 0, 0);
        check("fullswap_count", dut.count, 15);
        check("fullswap_pos", issue_pos, 1);
        check("fullswap_cmt_en", cmt_en, 2'b01);
        set_wb(0, 4'd2, 32'h3, 0, 0);
        set_wb(1, 4'd3, 32'h4, 0, 0);
        step();
        wb_en = '0;
        step();
        check("pre_rst_cmt_en", cmt_en, 2'b11);
        check("pre_rst_count", dut.count, 13);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_cmt_en", cmt_en, 0);
        check("arst_count", dut.count, 0);
        check("arst_issue_pos", issue_pos, 0);
        check("arst_full", rob_full, 0);
        #1;
        rst = 1'b0;
        step();

        // rdy low freezes everything
        issue_one(5'd9, KIND_REG, 0, 0, 1, 32'h99);
        issue_one(5'd10, KIND_REG, 0, 0, 0, 0);
        check("hold_pre_cmt_en", cmt_en, 2'b01);
        rdy = 1'b0;
        issue = 1'b1;
        set_wb(0, 4'd1, 32'h77, 0, 0);
        step(); step();
        check("hold_cmt_en", cmt_en, 2'b01);
        check("hold_cmt_val", cmt_val[31:0], 32'h99);
        check("hold_issue_pos", issue_pos, 2);
        check("hold_count", dut.count, 1);
        rdy = 1'b1;
        issue = 1'b0;
        wb_en = '0;
        step();
        check("resume_cmt_en", cmt_en, 0);
        check("resume_count", dut.count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_wide.md
ROB_WIDE -- requirements
Module: rob_wide

Interface
REQ-001 Parameter ROB_DEPTH, default 16, entry count; power of two, minimum 4.
REQ-002 Parameter WB_PORTS, default 2, number of result writeback ports (ALU, LSB, ...).
REQ-003 Parameter XLEN, default 32, data and address width.
REQ-004 Parameter REG_W, default 5, architectural register index width; POS_W = log2(ROB_DEPTH).
REQ-005 Clock and reset: one clock `clk` and reset `rst`; `rst` is asynchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 rdy  in  1  global enable; when low, all state holds.
REQ-009 issue, issue_rd, issue_kind[1:0], issue_pc, issue_pred_jump, issue_ready, issue_val  in  1/REG_W/2/XLEN/1/1/XLEN  new entry at tail; kind: 0 = reg-write, 1 = store, 2 = branch.
REQ-010 issue_pos  out  POS_W  tail index the next issue occupies.
REQ-011 rob_full  out  1  asserted when count >= ROB_DEPTH-1, giving one issue of slack.
REQ-012 wb_en, wb_pos, wb_val, wb_jump, wb_target  in  WB_PORTS x (1/POS_W/XLEN/1/XLEN), packed  result broadcasts.
REQ-013 rs1_pos/rs2_pos  in  POS_W; rs1_ready/rs2_ready out 1; rs1_val/rs2_val  out  XLEN  operand query.
REQ-014 cmt_en  out  2; cmt_rd  out  2xREG_W; cmt_val  out  2xXLEN; cmt_pos  out  2xPOS_W  registered register-file commit slots.
REQ-015 lsb_store, lsb_store_pos  out  1/POS_W  registered store-commit pulse.
REQ-016 br_cmt, br_cmt_jump, br_cmt_pc  out  1/1/XLEN  predictor update pulse.
REQ-017 rollback, set_pc_en, set_pc  out  1/1/XLEN  flush pulse and fetch redirect.

Function
REQ-018 Head, tail and a count of POS_W+1 bits are held; empty is count==0; pointers wrap modulo ROB_DEPTH.
REQ-019 Issue is accepted when issue && rdy && !rollback; the caller guarantees !rob_full. The entry becomes valid with ready=issue_ready and val=issue_val.
REQ-020 Writeback: wb_en[k] sets val, ready, res_jump and res_target at wb_pos[k]; on a same-position collision the lowest k wins; a writeback to an invalid entry is ignored.
REQ-021 Operand query is combinational with forwarding: ready if the entry is ready or a same-cycle wb matches; the forwarded value takes priority over the stored one.
REQ-022 Slot 0 commits when count>0 and ready[head].
REQ-023 Slot 1 commits when slot 0 commits, count>1 and ready[head+1], and neither entry is a store or a branch.
REQ-024 A store commit pulses lsb_store; a reg-write commit pulses cmt_en[i]; a branch commit pulses br_cmt and writes no register. Every commit output is registered (1-cycle latency) and deasserts the next cycle.
REQ-025 Mispredict (pred_jump != res_jump) in a committing branch causes the next cycle to assert rollback=1, set_pc_en=1 and set_pc=that entry's res_target.
REQ-026 In that cycle, head=tail=count=0 and every valid/ready bit is cleared. Issue and wb inputs in the rollback cycle are ignored, and rollback lasts exactly one cycle.
REQ-027 Count update: count_next = count + accepted_issue - commits; a simultaneous issue and commit with count==ROB_DEPTH-1 is legal.

Reset
REQ-028 On rst: head=tail=count=0; all valid/ready bits cleared; every output register (cmt_en, lsb_store, br_cmt, rollback, set_pc_en, set_pc, cmt_*) set to 0, asynchronously and regardless of rdy.
REQ-029 Payload arrays (val, pc, rd) need no reset.

Structure
REQ-030 Entry kind encodings, the ROB_DEPTH default and XLEN belong in the shared macros/package file.
REQ-031 One sub-module, rob_commit_sel, holds the combinational two-slot commit eligibility and mispredict detection.

Verification
REQ-032 Issue 3 reg-writes; wb all ready -> cycle N commits positions 0 and 1 together, N+1 commits position 2; count ends at 0.
REQ-033 Fill to 15 entries (DEPTH 16) -> rob_full=1; one commit -> rob_full drops, and tail wraps from 15 to 0 correctly.
REQ-034 Branch with pred=0, wb jump=1, target 0x100 at head -> next cycle rollback=1, set_pc=0x100; the following cycle count=0 and rollback=0.
REQ-035 Store at head+1 behind a ready reg-write -> single-slot commit, then lsb_store pulse one cycle later with lsb_store_pos correct.
REQ-036 wb ports 0 and 1 both target pos 4 with vals 0xA and 0xB -> stored val 0xA; a same-cycle rs1 query at pos 4 -> ready=1, val=0xA.
REQ-037 Assert rst mid-stream with 8 entries -> outputs go 0 immediately, before the next clk edge; hold rdy=0 -> no pointer or output change.
